pet_combat_sequencer: RTL
=========================

# pet_combat_sequencer

Turn-based combat controller that runs after both players have selected their active pets. It loads the two 9-bit pet stat words and collects one action per player per round from the keyboard tracker's 5-bit key code. It then resolves damage, tracks HP, and reports the winner with a one-cycle done pulse. It sits between the pet-select control FSM (which supplies `start` and stat words) and the display/HEX debug logic.

## Interface
- `TIMEOUT_CYCLES`, default 16'd50000: cycles a player may idle in a wait state before defend is auto-selected.
- `MAX_ROUNDS`, default 8'd16: round limit before a decision on remaining HP.
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: synchronous, active-low; clock `clk`.
- `start` in 1: begin combat; sampled only in IDLE.
- `p1_pet` in 9: player-1 stats, HP [2:0], DEF [5:3], ATK [8:6].
- `p2_pet` in 9: player-2 stats, same packing.
- `kstates` in 5: key code. 9 = P1 attack, 10 = P1 defend, 11 = P2 attack, 12 = P2 defend, any other value = no action.
- `busy` out 1: high from LOAD through DONE inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw.
- `p1_hp`, `p2_hp` out 3 each: live HP.
- `turn` out 1: 0 while waiting for P1, 1 while waiting for P2.
- `rounds` out 8: completed rounds.
- `state_dbg` out 4: state encoding for HEX debug.

## Operation
- States and encodings: IDLE 0, LOAD 1, WAIT_P1 2, REL_P1 3, WAIT_P2 4, REL_P2 5, RESOLVE 6, CHECK 7, DONE 8.
- IDLE → LOAD on `start`=1; `start` is ignored in every other state.
- LOAD:
  - latches both stat words and copies HP fields to `p1_hp`/`p2_hp`.
  - clears `rounds`, `winner` and the timeout counter.
  - → CHECK if either HP = 0, else → WAIT_P1.
- WAIT_P1:
  - `kstates` 9 or 10 → records the action, → REL_P1.
  - Timeout counter reaching `TIMEOUT_CYCLES`-1 → records defend, → WAIT_P2 (REL_P1 is skipped).
  - P2 codes are ignored here.
- REL_P1: holds until `kstates` is neither 9 nor 10, then → WAIT_P2. This blocks auto-repeat from a held key.
- WAIT_P2 / REL_P2: same as the P1 pair using codes 11/12; exit goes to RESOLVE.
- Timeout counter clears on entry to each WAIT state.
- RESOLVE damage rules:
  - eff_def = DEF + 1 if the defender chose defend, else DEF; computed in 4 bits, no overflow.
  - dmg = ATK − eff_def if ATK > eff_def, else 1; computed in 4 bits.
  - Floor: new HP = HP − dmg if HP > dmg, else 0.
- RESOLVE ordering:
  - P1's attack is applied first.
  - If P2's HP hits 0, P2's attack is discarded.
  - A player who defends deals no damage.
  - Both defend → no HP change.
- RESOLVE increments `rounds`, saturating at 255.
- CHECK decisions:
  - Both HP 0 → winner 11.
  - p2_hp = 0 → 01; p1_hp = 0 → 10.
  - Else if `rounds` = `MAX_ROUNDS` → higher HP wins, equal HP → 11.
  - Else → WAIT_P1 (`turn`=0).
  - → DONE whenever a winner is set.
- DONE: `done`=1 for one cycle, → IDLE. `winner`, HP and `rounds` hold until the next LOAD.
- Reset mid-combat: returns to IDLE next edge with all outputs at reset values; any in-progress round is discarded.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `turn` = 0.
  - `winner` 00, `p1_hp`/`p2_hp` 0, `rounds` 0, `state_dbg` 0.
- All outputs are registered; `state_dbg` equals the current state register.
- `start` at edge N → LOAD at N+1 → WAIT_P1 at N+2; `busy` rises at N+1.
- Valid key at edge M in WAIT_P1 → REL_P1 at M+1; minimum one cycle in REL_P1.
- Action 11/12 at edge K in WAIT_P2 (no release pending):
  - K+1 REL_P2.
  - HP and `rounds` updated at the edge leaving RESOLVE.
  - CHECK the following cycle; `done` two cycles after RESOLVE when the game ends.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after WAIT-state entry.

## Test plan
- P1 = 9'b101_010_111 (ATK5 DEF2 HP7), P2 = 9'b011_100_100 (ATK3 DEF4 HP4); keys 9 then 11 → p2_hp=3, p1_hp=6, rounds=1, back in WAIT_P1.
- Same stats; keys 9 then 12 (P2 defends, eff_def 5) → dmg 1 (minimum), p2_hp=3, p1_hp unchanged at 7.
- P1 = ATK7 DEF1 HP7, P2 = ATK7 DEF1 HP4; keys 9, 11 → P2 HP floored to 0, P2 attack discarded, p1_hp=7, winner=01, one `done` pulse.
- Hold `kstates`=9 for 20 cycles in WAIT_P1 → exactly one P1 action recorded, stays in REL_P1 until release. With `TIMEOUT_CYCLES`=4 and no P2 key → auto-defend after 4 cycles.
- `MAX_ROUNDS`=2, both defend twice → winner by HP (7 vs 4 → 01); equal HP → 11.
- Assert `reset`=0 in WAIT_P2, and separately pulse `start` while busy → IDLE with all outputs zero next cycle; `start` while busy has no effect.

Source files
------------

// File: rtl/pet_combat_sequencer_if.sv
// Signal bundle between the pet-select FSM, the combat sequencer and the display/HEX logic.
// Names follow the sequencer's point of view: i_ flows into it, o_ flows out of it.
interface pet_combat_sequencer_if;
   logic       i_start;
   logic [8:0] i_p1_pet;
   logic [8:0] i_p2_pet;
   logic [4:0] i_kstates;
   logic       o_busy;
   logic       o_done;
   logic [1:0] o_winner;
   logic [2:0] o_p1_hp;
   logic [2:0] o_p2_hp;
   logic       o_turn;
   logic [7:0] o_rounds;
   logic [3:0] o_state_dbg;

   modport master (
      output i_start, i_p1_pet, i_p2_pet, i_kstates,
      input  o_busy, o_done, o_winner, o_p1_hp, o_p2_hp, o_turn, o_rounds, o_state_dbg
   );

   modport slave (
      input  i_start, i_p1_pet, i_p2_pet, i_kstates,
      output o_busy, o_done, o_winner, o_p1_hp, o_p2_hp, o_turn, o_rounds, o_state_dbg
   );
endinterface

// File: rtl/pet_combat_sequencer.sv
// Turn-based pet combat controller: collects one action per player per round,
// resolves damage, tracks HP and rounds, and reports the winner with a done pulse.
module pet_combat_sequencer #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
   parameter logic [7:0]  MAX_ROUNDS     = 8'd16
) (
   input logic                   clk,
   input logic                   reset,
   pet_combat_sequencer_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD    = 4'd1,
      WAIT_P1 = 4'd2,
      REL_P1  = 4'd3,
      WAIT_P2 = 4'd4,
      REL_P2  = 4'd5,
      RESOLVE = 4'd6,
      CHECK   = 4'd7,
      DONE    = 4'd8
   } state_t;

   localparam logic [4:0] KEY_P1_ATK = 5'd9;
   localparam logic [4:0] KEY_P1_DEF = 5'd10;
   localparam logic [4:0] KEY_P2_ATK = 5'd11;
   localparam logic [4:0] KEY_P2_DEF = 5'd12;

   state_t      r_state;
   logic [2:0]  r_p1Atk, r_p1DefStat, r_p2Atk, r_p2DefStat;
   logic        r_p1Defend, r_p2Defend;
   logic [15:0] r_timer;
   logic [2:0]  r_p1Hp, r_p2Hp;
   logic [7:0]  r_rounds;
   logic [1:0]  r_winner;
   logic        r_busy, r_done, r_turn;

   logic       w_p1Key, w_p2Key, w_timeout, w_p2Strikes;
   logic [3:0] w_p1EffDef, w_p2EffDef, w_dmgToP1, w_dmgToP2;
   logic [2:0] w_p2HpAfterP1, w_p1HpNext;

   assign w_p1Key   = (bus.i_kstates == KEY_P1_ATK) || (bus.i_kstates == KEY_P1_DEF);
   assign w_p2Key   = (bus.i_kstates == KEY_P2_ATK) || (bus.i_kstates == KEY_P2_DEF);
   assign w_timeout = (r_timer == TIMEOUT_CYCLES - 16'd1);

   // P1 strikes first; P2 only strikes back if it chose attack and is still standing.
   assign w_p2EffDef    = {1'b0, r_p2DefStat} + {3'b000, r_p2Defend};
   assign w_dmgToP2     = ({1'b0, r_p1Atk} > w_p2EffDef) ? ({1'b0, r_p1Atk} - w_p2EffDef) : 4'd1;
   assign w_p2HpAfterP1 = r_p1Defend ? r_p2Hp :
                          (({1'b0, r_p2Hp} > w_dmgToP2) ? (r_p2Hp - w_dmgToP2[2:0]) : 3'd0);

   assign w_p1EffDef  = {1'b0, r_p1DefStat} + {3'b000, r_p1Defend};
   assign w_dmgToP1   = ({1'b0, r_p2Atk} > w_p1EffDef) ? ({1'b0, r_p2Atk} - w_p1EffDef) : 4'd1;
   assign w_p2Strikes = !r_p2Defend && (w_p2HpAfterP1 != 3'd0);
   assign w_p1HpNext  = !w_p2Strikes ? r_p1Hp :
                        (({1'b0, r_p1Hp} > w_dmgToP1) ? (r_p1Hp - w_dmgToP1[2:0]) : 3'd0);

   // Status outputs are updated alongside the state so they always match the state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_p1Atk     <= 3'd0;
         r_p1DefStat <= 3'd0;
         r_p2Atk     <= 3'd0;
         r_p2DefStat <= 3'd0;
         r_p1Defend  <= 1'b0;
         r_p2Defend  <= 1'b0;
         r_timer     <= 16'd0;
         r_p1Hp      <= 3'd0;
         r_p2Hp      <= 3'd0;
         r_rounds    <= 8'd0;
         r_winner    <= 2'b00;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_turn      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.i_start) begin
                  r_state <= LOAD;
                  r_busy  <= 1'b1;
               end
            end
            LOAD: begin
               r_p1Atk     <= bus.i_p1_pet[8:6];
               r_p1DefStat <= bus.i_p1_pet[5:3];
               r_p2Atk     <= bus.i_p2_pet[8:6];
               r_p2DefStat <= bus.i_p2_pet[5:3];
               r_p1Hp      <= bus.i_p1_pet[2:0];
               r_p2Hp      <= bus.i_p2_pet[2:0];
               r_rounds    <= 8'd0;
               r_winner    <= 2'b00;
               r_timer     <= 16'd0;
               r_turn      <= 1'b0;
               r_state     <= ((bus.i_p1_pet[2:0] == 3'd0) || (bus.i_p2_pet[2:0] == 3'd0)) ? CHECK : WAIT_P1;
            end
            WAIT_P1: begin
               if (w_p1Key) begin
                  r_p1Defend <= (bus.i_kstates == KEY_P1_DEF);
                  r_timer    <= 16'd0;
                  r_state    <= REL_P1;
               end else if (w_timeout) begin
                  r_p1Defend <= 1'b1;
                  r_timer    <= 16'd0;
                  r_turn     <= 1'b1;
                  r_state    <= WAIT_P2;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            REL_P1: begin
               if (!w_p1Key) begin
                  r_turn  <= 1'b1;
                  r_state <= WAIT_P2;
               end
            end
            WAIT_P2: begin
               if (w_p2Key) begin
                  r_p2Defend <= (bus.i_kstates == KEY_P2_DEF);
                  r_timer    <= 16'd0;
                  r_state    <= REL_P2;
               end else if (w_timeout) begin
                  r_p2Defend <= 1'b1;
                  r_timer    <= 16'd0;
                  r_turn     <= 1'b0;
                  r_state    <= RESOLVE;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            REL_P2: begin
               if (!w_p2Key) begin
                  r_turn  <= 1'b0;
                  r_state <= RESOLVE;
               end
            end
            RESOLVE: begin
               r_p2Hp   <= w_p2HpAfterP1;
               r_p1Hp   <= w_p1HpNext;
               r_rounds <= (r_rounds == 8'hFF) ? r_rounds : r_rounds + 8'd1;
               r_state  <= CHECK;
            end
            CHECK: begin
               if ((r_p1Hp == 3'd0) && (r_p2Hp == 3'd0)) begin
                  r_winner <= 2'b11;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (r_p2Hp == 3'd0) begin
                  r_winner <= 2'b01;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (r_p1Hp == 3'd0) begin
                  r_winner <= 2'b10;
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else if (r_rounds == MAX_ROUNDS) begin
                  r_winner <= (r_p1Hp > r_p2Hp) ? 2'b01 : ((r_p2Hp > r_p1Hp) ? 2'b10 : 2'b11);
                  r_done   <= 1'b1;
                  r_state  <= DONE;
               end else begin
                  r_turn  <= 1'b0;
                  r_state <= WAIT_P1;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_winner    = r_winner;
   assign bus.o_p1_hp     = r_p1Hp;
   assign bus.o_p2_hp     = r_p2Hp;
   assign bus.o_turn      = r_turn;
   assign bus.o_rounds    = r_rounds;
   assign bus.o_state_dbg = r_state;

endmodule
